shift_nbit_pipe: RTL
====================

// Module: shift_nbit_pipe
// PURPOSE
//  Pipelined, multi-mode barrel shifter for the PIM datapath: logical left, logical right,
//  arithmetic right and rotate right on a WIDTH-bit operand. Log-shifter stages are grouped
//  into registered pipeline slices. A valid/ready handshake with a TAG sideband lets the PIM
//  controller stream shift ops at one per cycle under back-pressure.
// PARAMETERS
//  WIDTH        32  operand width; power of two, >= 2 (elaboration error otherwise)
//  SHIFT_WIDTH   5  shift-amount width; >= $clog2(WIDTH) (elaboration error otherwise)
//  REG_EVERY     1  log stages per pipeline slice; 1..SHIFT_WIDTH
//  TAG_WIDTH     4  sideband tag width carried alongside each op; >= 1
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            synchronous reset, active-high
//  flush      in   1            synchronous pipeline clear, active-high
//  in_valid   in   1            input op valid
//  in_ready   out  1            block can accept an op this cycle
//  in_op      in   2            00 SLL, 01 SRL, 10 SRA, 11 ROR
//  in_a       in   WIDTH        operand
//  in_b       in   SHIFT_WIDTH  shift amount, unsigned
//  in_tag     in   TAG_WIDTH    opaque tag, returned unchanged with the result
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer accepts result
//  out_y      out  WIDTH        result
//  out_tag    out  TAG_WIDTH    tag of the op in out_y
// BEHAVIOUR
//  - Slices: L = ceil(SHIFT_WIDTH/REG_EVERY). Slice s applies stages i = s*REG_EVERY ..
//    min((s+1)*REG_EVERY, SHIFT_WIDTH)-1, then registers {valid, op, data, residual b, tag}.
//  - Stage i, when b[i]=1, shifts by 2^i: SLL zero-fill, SRL zero-fill, SRA sign-fill (sign =
//    current bit WIDTH-1), ROR wrap. If 2^i >= WIDTH: SLL/SRL give 0, SRA gives all sign bits,
//    ROR is identity (amount taken mod WIDTH).
//  - Latency: accepted op appears on out_* exactly L cycles later if no stall.
//  - Global-stall pipeline: adv = !out_valid || out_ready; in_ready = adv. All slices load
//    only when adv=1. Bubbles are not collapsed. Throughput 1 op/cycle when out_ready held high.
//  - Input accepted when in_valid && in_ready; slice-0 valid loads in_valid && adv.
//  - Output held stable (out_y, out_tag, out_valid) while out_valid && !out_ready.
//  - flush: all slice valids cleared next cycle; op presented in the flush cycle is dropped
//    (in_ready still reflects adv; input is discarded). flush has priority over loads.
//  - rst: all slice valids 0, data/tag/op registers 0; out_valid=0, out_y=0, out_tag=0,
//    in_ready=1 in the first cycle after reset. Reset mid-stream drops all in-flight ops.
//  - Arithmetic: all shifts purely bitwise on WIDTH bits; no overflow/status flags.
//  - No X propagation: data registers load only when their valid input is 1.
// STRUCTURE
//  - Package pim_shift_pkg: typedef enum logic [1:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA,
//    SH_ROR}; function for L (slice count).
//  - Sub-module shift_stage (combinational, params WIDTH, AMT): op, en, a -> y; one log stage.
//    Top generates SHIFT_WIDTH instances and the L slice registers.
// TESTING
//  - WIDTH=32,L=5: SRA a=0x8000_0010,b=4 -> y=0xF800_0001 after 5 cycles, tag echoed.
//  - SLL a=0x0000_0001,b=31 -> 0x8000_0000; ROR a=0x1234_5678,b=8 -> 0x7812_3456; SRL
//    a=0xFFFF_FFFF,b=0 -> 0xFFFF_FFFF.
//  - SHIFT_WIDTH=6: b=40: SLL/SRL -> 0, SRA of 0x8000_0000 -> 0xFFFF_FFFF, ROR
//    0x0000_00FF b=40 -> 0xFF00_0000 (mod 32 = 8).
//  - 20 back-to-back ops, out_ready random 50%: results in order, none lost/duplicated,
//    out_* stable while stalled; with out_ready=1 one result per cycle.
//  - flush with 3 ops in flight -> no out_valid for those ops; next op after flush returns
//    after L cycles; rst asserted mid-stream -> out_valid=0, out_y=0 next cycle.
//  - REG_EVERY=SHIFT_WIDTH (L=1) and REG_EVERY=2 (L=3): latency matches L, random ops
//    vs. reference model, 10k vectors, all four op codes.

Source files
------------

// File: rtl/pim_shift_pkg.sv
// Shared types and helpers for the pipelined PIM barrel shifter.
package pim_shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Number of registered slices when reg_every log stages share one slice.
  function automatic int unsigned num_slices(input int unsigned shift_width,
                                             input int unsigned reg_every);
    return (shift_width + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational log-shifter stage: shifts by the constant AMT when enabled.
module shift_stage
  import pim_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT   = 1
) (
  input  shift_op_e          op_i,
  input  logic               en_i,
  input  logic [WIDTH-1:0]   a_i,
  output logic [WIDTH-1:0]   y_o
);

  logic [WIDTH-1:0] sll, srl, sra, ror;

  // A power-of-two amount >= WIDTH is a multiple of WIDTH, so rotate is identity.
  if (AMT >= WIDTH) begin : g_big
    assign sll = '0;
    assign srl = '0;
    assign sra = {WIDTH{a_i[WIDTH-1]}};
    assign ror = a_i;
  end else begin : g_small
    assign sll = a_i << AMT;
    assign srl = a_i >> AMT;
    assign sra = $signed(a_i) >>> AMT;
    assign ror = (a_i >> AMT) | (a_i << (WIDTH - AMT));
  end

  always_comb begin
    y_o = a_i;
    if (en_i) begin
      unique case (op_i)
        SH_SLL: y_o = sll;
        SH_SRL: y_o = srl;
        SH_SRA: y_o = sra;
        SH_ROR: y_o = ror;
      endcase
    end
  end

endmodule

// File: rtl/shift_nbit_pipe.sv
// Pipelined multi-mode barrel shifter with valid/ready handshake and tag sideband.
module shift_nbit_pipe
  import pim_shift_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned REG_EVERY   = 1,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [SHIFT_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int unsigned L = num_slices(SHIFT_WIDTH, REG_EVERY);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("WIDTH must be a power of two >= 2");
  end
  if (SHIFT_WIDTH < $clog2(WIDTH)) begin : g_bad_shift_width
    $error("SHIFT_WIDTH must be >= clog2(WIDTH)");
  end
  if (REG_EVERY < 1 || REG_EVERY > SHIFT_WIDTH) begin : g_bad_reg_every
    $error("REG_EVERY must be in 1..SHIFT_WIDTH");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("TAG_WIDTH must be >= 1");
  end

  logic [L-1:0]           valid_q, valid_d;
  shift_op_e              op_q   [L];
  shift_op_e              op_d   [L];
  logic [WIDTH-1:0]       data_q [L];
  logic [WIDTH-1:0]       data_d [L];
  logic [SHIFT_WIDTH-1:0] b_q    [L];
  logic [SHIFT_WIDTH-1:0] b_d    [L];
  logic [TAG_WIDTH-1:0]   tag_q  [L];
  logic [TAG_WIDTH-1:0]   tag_d  [L];

  // Inputs seen by each slice: the port for slice 0, the previous register otherwise.
  logic [L-1:0]           src_v;
  shift_op_e              src_op  [L];
  logic [WIDTH-1:0]       src_a   [L];
  logic [SHIFT_WIDTH-1:0] src_b   [L];
  logic [TAG_WIDTH-1:0]   src_tag [L];
  logic [WIDTH-1:0]       slice_y [L];
  logic [WIDTH-1:0]       stage_y [SHIFT_WIDTH];

  logic adv;

  for (genvar s = 0; s < L; s++) begin : g_slice
    localparam int unsigned End = ((s + 1) * REG_EVERY < SHIFT_WIDTH) ?
                                  (s + 1) * REG_EVERY : SHIFT_WIDTH;
    if (s == 0) begin : g_first
      assign src_v[s]   = in_valid;
      assign src_op[s]  = shift_op_e'(in_op);
      assign src_a[s]   = in_a;
      assign src_b[s]   = in_b;
      assign src_tag[s] = in_tag;
    end else begin : g_next
      assign src_v[s]   = valid_q[s-1];
      assign src_op[s]  = op_q[s-1];
      assign src_a[s]   = data_q[s-1];
      assign src_b[s]   = b_q[s-1];
      assign src_tag[s] = tag_q[s-1];
    end
    assign slice_y[s] = stage_y[End-1];
  end

  for (genvar i = 0; i < SHIFT_WIDTH; i++) begin : g_stage
    localparam int unsigned S = i / REG_EVERY;
    logic [WIDTH-1:0] stage_a;
    if (i % REG_EVERY == 0) begin : g_head
      assign stage_a = src_a[S];
    end else begin : g_chain
      assign stage_a = stage_y[i-1];
    end
    shift_stage #(
      .WIDTH (WIDTH),
      .AMT   (32'd1 << i)
    ) u_stage (
      .op_i (src_op[S]),
      .en_i (src_b[S][i]),
      .a_i  (stage_a),
      .y_o  (stage_y[i])
    );
  end

  assign adv       = !valid_q[L-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[L-1];
  assign out_y     = data_q[L-1];
  assign out_tag   = tag_q[L-1];

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    b_d     = b_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = '0;
    end else if (adv) begin
      valid_d = src_v;
      for (int s = 0; s < L; s++) begin
        // Payload follows valid only, so bubbles never load X.
        if (src_v[s]) begin
          op_d[s]   = src_op[s];
          data_d[s] = slice_y[s];
          b_d[s]    = src_b[s];
          tag_d[s]  = src_tag[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < L; s++) begin
        op_q[s]   <= SH_SLL;
        data_q[s] <= '0;
        b_q[s]    <= '0;
        tag_q[s]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

endmodule
